// File: rtl/servisia_uart_loader.sv
`default_nettype none
// ============================================================================
// Module      : servisia_uart_loader
// Description : UART (8N1) boot loader. It waits for the sync byte 0xA5 and a
//               16-bit little-endian length, then writes that many bytes to
//               SRAM and releases the CPU reset.
// Revision    : 1.0 - initial release
// ============================================================================
module servisia_uart_loader #(
    parameter int CLKS_PER_BIT = 16,
    parameter int AW           = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_i,
    output logic [AW-1:0] sram_waddr_o,
    output logic [7:0]    sram_wdata_o,
    output logic          sram_wen_o,
    output logic          cpu_rst_no,
    output logic          busy_o,
    output logic          frame_err_o
);

    localparam int              c_TW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_TW-1:0] c_HALF_LAST = c_TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_TW-1:0] c_BIT_LAST  = c_TW'(CLKS_PER_BIT - 1);
    localparam logic [7:0]      c_SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        SYNC   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        DONE   = 3'd4
    } p_state_t;

    // ------------------------------------------------------------------------
    // Receive line synchronizer and falling-edge detector
    // ------------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_sync;
    logic r_rx_prev;
    logic w_fall;

    // rst_n is active-high despite its name; every flop resets asynchronously.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_fall = r_rx_prev & ~r_rx_sync;

    // ------------------------------------------------------------------------
    // 8N1 receiver
    // ------------------------------------------------------------------------
    rx_state_t       r_rx_state;
    rx_state_t       w_rx_next;
    logic [c_TW-1:0] r_rx_timer;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_rx_shift;
    logic            w_half_tick;
    logic            w_bit_tick;
    logic            w_byte_valid;
    logic            w_stop_err;

    assign w_half_tick = (r_rx_timer == c_HALF_LAST);
    assign w_bit_tick  = (r_rx_timer == c_BIT_LAST);

    always_comb begin
        w_rx_next    = r_rx_state;
        w_byte_valid = 1'b0;
        w_stop_err   = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (w_fall) begin
                    w_rx_next = RX_START;
                end
            end
            RX_START: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (w_half_tick) begin
                    w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_bit_tick && (r_bit_cnt == 3'd7)) begin
                    w_rx_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_bit_tick) begin
                    w_rx_next    = RX_IDLE;
                    w_byte_valid = r_rx_sync;
                    w_stop_err   = ~r_rx_sync;
                end
            end
            default: begin
                w_rx_next = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_rx_state <= RX_IDLE;
            r_rx_timer <= '0;
            r_bit_cnt  <= 3'd0;
            r_rx_shift <= 8'd0;
        end else begin
            r_rx_state <= w_rx_next;
            if ((r_rx_state == RX_IDLE) || ((r_rx_state == RX_START) && w_half_tick) || w_bit_tick) begin
                r_rx_timer <= '0;
            end else begin
                r_rx_timer <= r_rx_timer + c_TW'(1);
            end
            if (r_rx_state == RX_START) begin
                r_bit_cnt <= 3'd0;
            end else if ((r_rx_state == RX_DATA) && w_bit_tick) begin
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            end
        end
    end

    // ------------------------------------------------------------------------
    // Loader protocol
    // ------------------------------------------------------------------------
    p_state_t        r_p_state;
    p_state_t        w_p_next;
    logic [15:0]     r_len;
    logic [AW-1:0]   r_addr;
    logic            r_wen;
    logic [AW-1:0]   r_waddr;
    logic [7:0]      r_wdata;
    logic            r_frame_err;
    logic            w_len_lo_ld;
    logic            w_len_hi_ld;
    logic            w_wr;

    always_comb begin
        w_p_next    = r_p_state;
        w_len_lo_ld = 1'b0;
        w_len_hi_ld = 1'b0;
        w_wr        = 1'b0;
        if ((r_p_state != DONE) && w_stop_err) begin
            w_p_next = SYNC;
        end else begin
            case (r_p_state)
                SYNC: begin
                    if (w_byte_valid && (r_rx_shift == c_SYNC_BYTE)) begin
                        w_p_next = LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (w_byte_valid) begin
                        w_len_lo_ld = 1'b1;
                        w_p_next    = LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (w_byte_valid) begin
                        w_len_hi_ld = 1'b1;
                        w_p_next    = ({r_rx_shift, r_len[7:0]} == 16'd0) ? DONE : DATA;
                    end
                end
                DATA: begin
                    // The count only reaches zero right after a write, so DONE
                    // follows the final write strobe by one cycle.
                    if (r_len == 16'd0) begin
                        w_p_next = DONE;
                    end else if (w_byte_valid) begin
                        w_wr = 1'b1;
                    end
                end
                DONE: begin
                    w_p_next = DONE;
                end
                default: begin
                    w_p_next = SYNC;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_p_state   <= SYNC;
            r_len       <= 16'd0;
            r_addr      <= '0;
            r_wen       <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= 8'd0;
            r_frame_err <= 1'b0;
        end else begin
            r_p_state   <= w_p_next;
            r_wen       <= w_wr;
            r_frame_err <= w_stop_err && (r_p_state != DONE);
            if (w_len_lo_ld) begin
                r_len[7:0] <= r_rx_shift;
            end
            if (w_len_hi_ld) begin
                r_len[15:8] <= r_rx_shift;
                r_addr      <= '0;
            end
            if (w_wr) begin
                r_waddr <= r_addr;
                r_wdata <= r_rx_shift;
                r_addr  <= r_addr + AW'(1);
                r_len   <= r_len - 16'd1;
            end
        end
    end

    assign sram_waddr_o = r_waddr;
    assign sram_wdata_o = r_wdata;
    assign sram_wen_o   = r_wen;
    assign frame_err_o  = r_frame_err;
    assign cpu_rst_no   = (r_p_state == DONE);
    assign busy_o       = (r_p_state == LEN_LO) || (r_p_state == LEN_HI) || (r_p_state == DATA);

endmodule
`default_nettype wire

// File: tb/tb_servisia_uart_loader.sv
`default_nettype none
// Directed bench for servisia_uart_loader: one default-width instance and one
// AW=4 instance for the address-wrap case.
module tb_servisia_uart_loader;

    localparam int CPB = 16;

    logic        clk;
    logic        rst;
    logic        rx;
    logic        rx4;
    logic [13:0] waddr;
    logic [7:0]  wdata;
    logic        wen, cpu, busy, ferr;
    logic [3:0]  waddr4;
    logic [7:0]  wdata4;
    logic        wen4, cpu4, busy4, ferr4;

    int vectors = 0;
    int miscompares = 0;

    servisia_uart_loader #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst), .rx_i(rx),
        .sram_waddr_o(waddr), .sram_wdata_o(wdata), .sram_wen_o(wen),
        .cpu_rst_no(cpu), .busy_o(busy), .frame_err_o(ferr)
    );

    servisia_uart_loader #(.CLKS_PER_BIT(CPB), .AW(4)) dut4 (
        .clk(clk), .rst_n(rst), .rx_i(rx4),
        .sram_waddr_o(waddr4), .sram_wdata_o(wdata4), .sram_wen_o(wen4),
        .cpu_rst_no(cpu4), .busy_o(busy4), .frame_err_o(ferr4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write/pulse monitors, sampled on the falling edge.
    int wa_q[$], wd_q[$], wa4_q[$], wd4_q[$];
    int consec, bad_wen, ferr_cnt, lag, since, consec4, bad4;
    logic prev_wen, prev_cpu, prev_wen4;

    always @(negedge clk) begin
        if (wen === 1'b1) begin
            wa_q.push_back(int'(waddr));
            wd_q.push_back(int'(wdata));
            if (prev_wen === 1'b1) consec++;
            if (busy !== 1'b1) bad_wen++;
            since = 0;
        end else begin
            since++;
        end
        if (cpu === 1'b1 && prev_cpu === 1'b0) lag = since;
        if (ferr === 1'b1) ferr_cnt++;
        prev_wen = wen;
        prev_cpu = cpu;
        if (wen4 === 1'b1) begin
            wa4_q.push_back(int'(waddr4));
            wd4_q.push_back(int'(wdata4));
            if (prev_wen4 === 1'b1) consec4++;
            if (busy4 !== 1'b1) bad4++;
        end
        prev_wen4 = wen4;
    end

    task automatic clear_mon();
        wa_q.delete(); wd_q.delete(); wa4_q.delete(); wd4_q.delete();
        consec = 0; bad_wen = 0; ferr_cnt = 0; lag = -1; since = 0;
        consec4 = 0; bad4 = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        clear_mon();
    endtask

    task automatic drive(input bit to4, input logic v);
        if (to4) rx4 = v;
        else     rx  = v;
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input bit to4);
        drive(to4, 1'b0);
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(to4, b[i]);
            repeat (CPB) @(negedge clk);
        end
        drive(to4, stop);
        repeat (CPB) @(negedge clk);
        drive(to4, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; rx = 1'b1; rx4 = 1'b1;
        #2 rst = 1'b1;
        #1;
        vectors++; if (wen !== 1'b0)    begin miscompares++; $display("FAIL reset_wen: got %b want 0", wen); end
        vectors++; if (waddr !== 14'd0) begin miscompares++; $display("FAIL reset_waddr: got %0h want 0", waddr); end
        vectors++; if (wdata !== 8'd0)  begin miscompares++; $display("FAIL reset_wdata: got %0h want 0", wdata); end
        vectors++; if (cpu !== 1'b0)    begin miscompares++; $display("FAIL reset_cpu: got %b want 0", cpu); end
        vectors++; if (busy !== 1'b0)   begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (ferr !== 1'b0)   begin miscompares++; $display("FAIL reset_ferr: got %b want 0", ferr); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        clear_mon();
    endtask

    task automatic test_basic_load();
        logic [7:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
        do_reset();
        send(8'hA5, 1'b1, 1'b0);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_after_sync: got %b want 1", busy); end
        send(8'h03, 1'b1, 1'b0);
        send(8'h00, 1'b1, 1'b0);
        send(8'h11, 1'b1, 1'b0);
        send(8'h22, 1'b1, 1'b0);
        send(8'h33, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        vectors++; if (wa_q.size() !== 3) begin miscompares++; $display("FAIL basic_count: got %0d want 3", wa_q.size()); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (i >= wa_q.size() || wa_q[i] !== i || wd_q[i] !== int'(exp_d[i])) begin
                miscompares++;
                $display("FAIL basic_write%0d: got (%0h,%0h) want (%0h,%0h)", i,
                         (i < wa_q.size()) ? wa_q[i] : -1, (i < wd_q.size()) ? wd_q[i] : -1, i, exp_d[i]);
            end
        end
        vectors++; if (lag !== 1)      begin miscompares++; $display("FAIL basic_cpu_lag: got %0d want 1", lag); end
        vectors++; if (cpu !== 1'b1)   begin miscompares++; $display("FAIL basic_cpu: got %b want 1", cpu); end
        vectors++; if (busy !== 1'b0)  begin miscompares++; $display("FAIL basic_busy_done: got %b want 0", busy); end
        vectors++; if (consec !== 0 || bad_wen !== 0) begin miscompares++; $display("FAIL basic_wen_shape: got consec=%0d outside=%0d want 0/0", consec, bad_wen); end
        // DONE must ignore further traffic, including framing errors.
        send(8'hA5, 1'b0, 1'b0);
        send(8'h44, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        vectors++; if (ferr_cnt !== 0)    begin miscompares++; $display("FAIL done_ferr: got %0d want 0", ferr_cnt); end
        vectors++; if (cpu !== 1'b1)      begin miscompares++; $display("FAIL done_cpu: got %b want 1", cpu); end
        vectors++; if (wa_q.size() !== 3) begin miscompares++; $display("FAIL done_writes: got %0d want 3", wa_q.size()); end
    endtask

    task automatic test_sync_filter();
        do_reset();
        send(8'h00, 1'b1, 1'b0);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL filter_00: got busy %b want 0", busy); end
        send(8'h5A, 1'b1, 1'b0);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL filter_5A: got busy %b want 0", busy); end
        send(8'hA5, 1'b1, 1'b0);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL filter_A5: got busy %b want 1", busy); end
        send(8'h00, 1'b1, 1'b0);
        vectors++; if (busy !== 1'b1 || cpu !== 1'b0) begin miscompares++; $display("FAIL filter_lenlo: got busy %b cpu %b want 1/0", busy, cpu); end
        send(8'h00, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        vectors++; if (cpu !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL filter_done: got cpu %b busy %b want 1/0", cpu, busy); end
        vectors++; if (wa_q.size() !== 0) begin miscompares++; $display("FAIL filter_writes: got %0d want 0", wa_q.size()); end
    endtask

    task automatic test_frame_error();
        do_reset();
        send(8'hA5, 1'b1, 1'b0);
        send(8'h02, 1'b1, 1'b0);
        send(8'h00, 1'b1, 1'b0);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ferr_busy_pre: got %b want 1", busy); end
        send(8'h55, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        vectors++; if (ferr_cnt !== 1) begin miscompares++; $display("FAIL ferr_pulses: got %0d want 1", ferr_cnt); end
        vectors++; if (busy !== 1'b0 || cpu !== 1'b0) begin miscompares++; $display("FAIL ferr_sync: got busy %b cpu %b want 0/0", busy, cpu); end
        vectors++; if (wa_q.size() !== 0) begin miscompares++; $display("FAIL ferr_writes: got %0d want 0", wa_q.size()); end
        send(8'hA5, 1'b1, 1'b0);
        send(8'h01, 1'b1, 1'b0);
        send(8'h00, 1'b1, 1'b0);
        send(8'h7E, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        vectors++;
        if (wa_q.size() !== 1 || wa_q[0] !== 0 || wd_q[0] !== 'h7E) begin
            miscompares++;
            $display("FAIL ferr_reload: got %0d writes, first (%0h,%0h) want 1 write (0,7e)", wa_q.size(),
                     (wa_q.size() > 0) ? wa_q[0] : -1, (wd_q.size() > 0) ? wd_q[0] : -1);
        end
        vectors++; if (cpu !== 1'b1) begin miscompares++; $display("FAIL ferr_reload_cpu: got %b want 1", cpu); end
    endtask

    task automatic test_glitch();
        do_reset();
        rx = 1'b0; repeat (3) @(negedge clk); rx = 1'b1;
        repeat (40) @(negedge clk);
        vectors++; if (busy !== 1'b0 || ferr_cnt !== 0 || wa_q.size() !== 0) begin miscompares++; $display("FAIL glitch_idle: got busy %b ferr %0d writes %0d want 0/0/0", busy, ferr_cnt, wa_q.size()); end
        send(8'hA5, 1'b1, 1'b0);
        rx = 1'b0; repeat (3) @(negedge clk); rx = 1'b1;
        repeat (40) @(negedge clk);
        vectors++; if (busy !== 1'b1 || ferr_cnt !== 0) begin miscompares++; $display("FAIL glitch_lenlo: got busy %b ferr %0d want 1/0", busy, ferr_cnt); end
        send(8'h01, 1'b1, 1'b0);
        send(8'h00, 1'b1, 1'b0);
        send(8'h99, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        vectors++;
        if (wa_q.size() !== 1 || wa_q[0] !== 0 || wd_q[0] !== 'h99 || cpu !== 1'b1) begin
            miscompares++;
            $display("FAIL glitch_load: got %0d writes cpu %b want 1 write (0,99) cpu 1", wa_q.size(), cpu);
        end
    endtask

    task automatic test_addr_wrap();
        do_reset();
        send(8'hA5, 1'b1, 1'b1);
        send(8'h12, 1'b1, 1'b1);
        send(8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 18; i++) begin
            vectors++;
            if (cpu4 !== 1'b0) begin miscompares++; $display("FAIL wrap_cpu_early%0d: got %b want 0", i, cpu4); end
            send(8'h40 + 8'(i), 1'b1, 1'b1);
        end
        repeat (3) @(negedge clk);
        vectors++; if (wa4_q.size() !== 18) begin miscompares++; $display("FAIL wrap_count: got %0d want 18", wa4_q.size()); end
        for (int i = 0; i < 18; i++) begin
            vectors++;
            if (i >= wa4_q.size() || wa4_q[i] !== (i % 16) || wd4_q[i] !== ('h40 + i)) begin
                miscompares++;
                $display("FAIL wrap_write%0d: got (%0h,%0h) want (%0h,%0h)", i,
                         (i < wa4_q.size()) ? wa4_q[i] : -1, (i < wd4_q.size()) ? wd4_q[i] : -1, i % 16, 'h40 + i);
            end
        end
        vectors++; if (cpu4 !== 1'b1 || busy4 !== 1'b0) begin miscompares++; $display("FAIL wrap_done: got cpu %b busy %b want 1/0", cpu4, busy4); end
        vectors++; if (consec4 !== 0 || bad4 !== 0) begin miscompares++; $display("FAIL wrap_wen_shape: got consec=%0d outside=%0d want 0/0", consec4, bad4); end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] b;
        do_reset();
        send(8'hA5, 1'b1, 1'b0);
        send(8'h04, 1'b1, 1'b0);
        send(8'h00, 1'b1, 1'b0);
        send(8'hAA, 1'b1, 1'b0);
        vectors++; if (wa_q.size() !== 1 || wd_q[0] !== 'hAA) begin miscompares++; $display("FAIL mid_first: got %0d writes want 1 of aa", wa_q.size()); end
        b = 8'hBB;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        #3 rst = 1'b1;
        #1;
        vectors++;
        if (wen !== 1'b0 || busy !== 1'b0 || cpu !== 1'b0 || waddr !== 14'd0 || wdata !== 8'd0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got wen %b busy %b cpu %b addr %0h data %0h want all 0", wen, busy, cpu, waddr, wdata);
        end
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send(8'hCC, 1'b1, 1'b0);
        send(8'hDD, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        vectors++; if (wa_q.size() !== 1) begin miscompares++; $display("FAIL mid_no_write: got %0d writes want 1", wa_q.size()); end
        vectors++; if (busy !== 1'b0 || cpu !== 1'b0) begin miscompares++; $display("FAIL mid_sync: got busy %b cpu %b want 0/0", busy, cpu); end
    endtask

    initial begin
        clear_mon();
        prev_wen = 1'b0; prev_cpu = 1'b0; prev_wen4 = 1'b0;
        test_reset();
        test_basic_load();
        test_sync_filter();
        test_frame_error();
        test_glitch();
        test_addr_wrap();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
